// File: rtl/systolic_data_setup_if.sv
// Operand-side bundle for the systolic skew buffer: shift enable, lane inputs and skewed lane outputs.
interface systolic_data_setup_if #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned LENGTH = 5
);

  logic             EN;
  logic [WIDTH-1:0] Inputs  [0:LENGTH-1];
  logic [WIDTH-1:0] Outputs [0:LENGTH-1];

  // Producer side (operand buffer / bench).
  modport master (
    output EN,
    output Inputs,
    input  Outputs
  );

  // Skew buffer side.
  modport slave (
    input  EN,
    input  Inputs,
    output Outputs
  );

endinterface

// File: rtl/systolic_data_setup.sv
// Input skew buffer: lane i is delayed by i+1 enabled stages to form the diagonal wavefront
// a systolic PE array consumes.
module systolic_data_setup #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned LENGTH = 5
) (
  input  logic                  CLK,
  input  logic                  SYNC_RST,
  systolic_data_setup_if.slave  bus
);

  for (genvar i = 0; i < LENGTH; i++) begin : g_lane
    // Triangular storage: this lane holds exactly i+1 stages.
    logic [WIDTH-1:0] lane_q [0:i];
    logic [WIDTH-1:0] lane_d [0:i];

    always_comb begin
      for (int k = 0; k <= i; k++) begin
        lane_d[k] = lane_q[k];
      end
      if (bus.EN) begin
        lane_d[0] = bus.Inputs[i];
        for (int k = 1; k <= i; k++) begin
          lane_d[k] = lane_q[k-1];
        end
      end
    end

    always_ff @(posedge CLK) begin
      for (int k = 0; k <= i; k++) begin
        if (SYNC_RST) begin
          lane_q[k] <= '0;
        end else begin
          lane_q[k] <= lane_d[k];
        end
      end
    end

    assign bus.Outputs[i] = lane_q[i];
  end

endmodule

// File: tb/tb_systolic_data_setup.sv
// Self-checking bench for systolic_data_setup using a history-queue scoreboard of enabled vectors.
module tb_systolic_data_setup;

  localparam int unsigned W = 8;
  localparam int unsigned L = 5;

  typedef logic [L-1:0][W-1:0] vec_t;

  logic CLK;
  logic SYNC_RST;
  int   checks;
  int   errors;

  // Scoreboard: vectors accepted on enabled edges since the last reset, newest at the back.
  vec_t hist[$];

  systolic_data_setup_if #(.WIDTH(W), .LENGTH(L)) bus ();

  systolic_data_setup #(.WIDTH(W), .LENGTH(L)) dut (
    .CLK      (CLK),
    .SYNC_RST (SYNC_RST),
    .bus      (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic logic [W-1:0] exp_lane(input int i);
    if (hist.size() > i) return hist[hist.size()-1-i][i];
    return '0;
  endfunction

  function automatic vec_t splat(input logic [W-1:0] val);
    vec_t v;
    for (int i = 0; i < L; i++) v[i] = val;
    return v;
  endfunction

  function automatic vec_t stream_vec(input int j);
    vec_t v;
    for (int i = 0; i < L; i++) v[i] = W'(10 * j + i);
    return v;
  endfunction

  function automatic vec_t rand_vec(input int unsigned hi);
    vec_t v;
    for (int i = 0; i < L; i++) v[i] = W'($urandom_range(hi, 0));
    return v;
  endfunction

  // Apply inputs, take one edge, update the scoreboard, then settle away from the edge.
  task automatic step(input logic en, input logic rst, input vec_t v);
    bus.EN   = en;
    SYNC_RST = rst;
    for (int i = 0; i < L; i++) bus.Inputs[i] = v[i];
    @(posedge CLK);
    if (rst) begin
      hist.delete();
    end else if (en) begin
      hist.push_back(v);
      if (hist.size() > L) void'(hist.pop_front());
    end
    #1;
  endtask

  task automatic test_reset();
    for (int e = 0; e < 2; e++) step(1'b1, 1'b1, splat(8'hFF));
    for (int i = 0; i < L; i++) begin
      checks++;
      if (bus.Outputs[i] !== '0) begin
        errors++;
        $display("FAIL reset lane%0d got %0h want 0", i, bus.Outputs[i]);
      end
    end
    for (int e = 0; e < L + 1; e++) begin
      step(1'b1, 1'b0, splat(8'h00));
      for (int i = 0; i < L; i++) begin
        checks++;
        if (bus.Outputs[i] !== '0) begin
          errors++;
          $display("FAIL reset_release lane%0d edge%0d got %0h want 0", i, e, bus.Outputs[i]);
        end
      end
    end
  endtask

  task automatic test_skew();
    logic [W-1:0] want;
    step(1'b1, 1'b1, splat(8'h00));
    for (int n = 1; n <= L + 2; n++) begin
      step(1'b1, 1'b0, (n == 1) ? splat(8'd7) : splat(8'd0));
      for (int i = 0; i < L; i++) begin
        want = (n == i + 1) ? 8'd7 : 8'd0;
        checks++;
        if (bus.Outputs[i] !== want) begin
          errors++;
          $display("FAIL skew lane%0d edge%0d got %0d want %0d", i, n, bus.Outputs[i], want);
        end
      end
    end
  endtask

  task automatic test_stream();
    int d;
    logic [W-1:0] want;
    step(1'b1, 1'b1, splat(8'h00));
    for (int n = 1; n <= 2 * L; n++) begin
      step(1'b1, 1'b0, (n <= L) ? stream_vec(n - 1) : splat(8'd0));
      for (int i = 0; i < L; i++) begin
        d    = n - 1 - i;
        want = (d >= 0 && d <= L - 1) ? W'(10 * d + i) : '0;
        checks++;
        if (bus.Outputs[i] !== want) begin
          errors++;
          $display("FAIL stream lane%0d edge%0d got %0d want %0d", i, n, bus.Outputs[i], want);
        end
        checks++;
        if (exp_lane(i) !== want) begin
          errors++;
          $display("FAIL stream_model lane%0d edge%0d got %0d want %0d", i, n, exp_lane(i), want);
        end
      end
    end
  endtask

  // The stall is invisible in terms of enabled edges: expected values index by n only.
  task automatic test_stall();
    int n;
    int d;
    logic [W-1:0] want;
    step(1'b1, 1'b1, splat(8'h00));
    n = 0;
    for (int c = 0; c < 2 * L + 3; c++) begin
      if (c >= 3 && c < 6) begin
        step(1'b0, 1'b0, rand_vec(255));
      end else begin
        n++;
        step(1'b1, 1'b0, (n <= L) ? stream_vec(n - 1) : splat(8'd0));
      end
      for (int i = 0; i < L; i++) begin
        d    = n - 1 - i;
        want = (n > 0 && d >= 0 && d <= L - 1) ? W'(10 * d + i) : '0;
        checks++;
        if (bus.Outputs[i] !== want) begin
          errors++;
          $display("FAIL stall lane%0d cycle%0d got %0d want %0d", i, c, bus.Outputs[i], want);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [W-1:0] want;
    step(1'b1, 1'b1, splat(8'h00));
    for (int j = 1; j <= L; j++) step(1'b1, 1'b0, stream_vec(j));
    step(1'b1, 1'b1, rand_vec(255));
    for (int i = 0; i < L; i++) begin
      checks++;
      if (bus.Outputs[i] !== '0) begin
        errors++;
        $display("FAIL reset_mid lane%0d got %0d want 0", i, bus.Outputs[i]);
      end
    end
    for (int n = 1; n <= L + 1; n++) begin
      step(1'b1, 1'b0, (n == 1) ? splat(8'd9) : splat(8'd0));
      for (int i = 0; i < L; i++) begin
        want = (n == i + 1) ? 8'd9 : 8'd0;
        checks++;
        if (bus.Outputs[i] !== want) begin
          errors++;
          $display("FAIL reset_mid_after lane%0d edge%0d got %0d want %0d",
                   i, n, bus.Outputs[i], want);
        end
      end
    end
  endtask

  task automatic test_random();
    logic rst;
    logic en;
    step(1'b1, 1'b1, splat(8'h00));
    for (int c = 0; c < 200; c++) begin
      rst = ($urandom_range(19, 0) == 0);
      en  = ($urandom_range(3, 0) != 0);
      step(en, rst, rand_vec(10));
      for (int i = 0; i < L; i++) begin
        checks++;
        if (bus.Outputs[i] !== exp_lane(i)) begin
          errors++;
          $display("FAIL random lane%0d cycle%0d got %0d want %0d",
                   i, c, bus.Outputs[i], exp_lane(i));
        end
      end
    end
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    SYNC_RST = 1'b1;
    bus.EN   = 1'b0;
    for (int i = 0; i < L; i++) bus.Inputs[i] = '0;
    #1;
    test_reset();
    test_skew();
    test_stream();
    test_stall();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
